// File: rtl/fetch_queue_unit_pkg.sv
// Shared entry type and default sizing for the instruction-fetch queue front end.
package fetch_queue_unit_pkg;

  localparam int FQ_PC_W  = 9;
  localparam int FQ_INS_W = 32;
  localparam int FQ_DEPTH = 4;
  localparam int FQ_PTR_W = $clog2(FQ_DEPTH);

  typedef struct packed {
    logic [FQ_PC_W-1:0]  pc;
    logic [FQ_INS_W-1:0] instr;
    logic                filled;
  } fq_entry_t;

  // Sequential fetch address; the add wraps at the PC width.
  function automatic logic [FQ_PC_W-1:0] fq_next_pc(input logic [FQ_PC_W-1:0] pc,
                                                     input logic [FQ_PC_W-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH-entry fetch queue storage: one allocate, one fill and one read/pop port, plus flush-all.
module fetch_queue_mem
  import fetch_queue_unit_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = FQ_PTR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                alloc,
  input  logic [PTR_W-1:0]    alloc_ptr,
  input  logic [FQ_PC_W-1:0]  alloc_pc,
  input  logic                fill,
  input  logic [PTR_W-1:0]    fill_ptr,
  input  logic [FQ_INS_W-1:0] fill_instr,
  input  logic                pop,
  input  logic [PTR_W-1:0]    rd_ptr,
  output fq_entry_t           head
);

  fq_entry_t entries_r [DEPTH];

  // Allocate, fill and pop never target the same entry in one cycle, so priority among them is moot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i].filled <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && (alloc_ptr == PTR_W'(i))) begin
          entries_r[i].pc     <= alloc_pc;
          entries_r[i].filled <= 1'b0;
        end else if (fill && (fill_ptr == PTR_W'(i))) begin
          entries_r[i].instr  <= fill_instr;
          entries_r[i].filled <= 1'b1;
        end else if (pop && (rd_ptr == PTR_W'(i))) begin
          entries_r[i].filled <= 1'b0;
        end
      end
    end
  end

  assign head = entries_r[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order memory requests and
// buffers responses for decode behind a valid/ready handshake, with redirect flush and halt.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int              PC_W     = FQ_PC_W,
  parameter int              INS_W    = FQ_INS_W,
  parameter int              DEPTH    = FQ_DEPTH,
  parameter int              PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic                       imem_rvalid,
  input  logic [INS_W-1:0]           imem_rdata,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       halt,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [PC_W-1:0]            id_pc,
  output logic [INS_W-1:0]           id_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam int              CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  STEP_PC  = PC_W'(PC_STEP);

  logic [PC_W-1:0]  pc_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] fill_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] occ_r;
  logic [CNT_W-1:0] pend_r;
  logic [CNT_W-1:0] drop_cnt_r;

  logic             issue_s;
  logic             fill_s;
  logic             drop_s;
  logic             pop_s;
  logic [CNT_W-1:0] drop_flush_s;
  fq_entry_t        head_s;

  // Issue, response routing and decode handshake; redirect suppresses all of them.
  always_comb begin
    issue_s      = 1'b0;
    fill_s       = 1'b0;
    drop_s       = 1'b0;
    id_valid     = 1'b0;
    pop_s        = 1'b0;
    drop_flush_s = drop_cnt_r;
    if (reset && !redirect) begin
      issue_s  = !halt && (occ_r < FULL_CNT);
      fill_s   = imem_rvalid && (drop_cnt_r == {CNT_W{1'b0}});
      drop_s   = imem_rvalid && (drop_cnt_r != {CNT_W{1'b0}});
      id_valid = head_s.filled;
      pop_s    = head_s.filled && id_ready;
    end else begin
      // pend_r is the unfilled-entry count; an rvalid this cycle retires one in-flight request.
      drop_flush_s = drop_cnt_r + pend_r - CNT_W'(imem_rvalid);
    end
  end

  assign imem_req  = issue_s;
  assign imem_addr = pc_r;
  assign id_pc     = head_s.pc;
  assign id_instr  = head_s.instr;
  assign occupancy = occ_r;

  // PC, pointers and counters; redirect flushes everything but remembers in-flight requests.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r       <= RESET_PC;
      wr_ptr_r   <= {PTR_W{1'b0}};
      fill_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      occ_r      <= {CNT_W{1'b0}};
      pend_r     <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (redirect) begin
      pc_r       <= redirect_pc;
      wr_ptr_r   <= {PTR_W{1'b0}};
      fill_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      occ_r      <= {CNT_W{1'b0}};
      pend_r     <= {CNT_W{1'b0}};
      drop_cnt_r <= drop_flush_s;
    end else begin
      if (issue_s) begin
        pc_r     <= fq_next_pc(pc_r, STEP_PC);
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (fill_s) begin
        fill_ptr_r <= fill_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      occ_r  <= occ_r + CNT_W'(issue_s) - CNT_W'(pop_s);
      pend_r <= pend_r + CNT_W'(issue_s) - CNT_W'(fill_s);
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .alloc      (issue_s),
    .alloc_ptr  (wr_ptr_r),
    .alloc_pc   (pc_r),
    .fill       (fill_s),
    .fill_ptr   (fill_ptr_r),
    .fill_instr (imem_rdata),
    .pop        (pop_s),
    .rd_ptr     (rd_ptr_r),
    .head       (head_s)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a fixed-latency in-order instruction memory model.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        halt;
  logic        id_ready;
  logic        id_valid;
  logic [8:0]  id_pc;
  logic [31:0] id_instr;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  logic [8:0]  mq_addr [$];
  int          mq_due  [$];
  logic [8:0]  log_pc  [$];
  logic [31:0] log_ins [$];

  fetch_queue_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_instr(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int idx, input logic [8:0] pc);
    if (log_pc.size() > idx) begin
      check_eq({tag, "_pc"}, log_pc[idx], pc);
      check_eq({tag, "_ins"}, log_ins[idx], exp_instr(pc));
    end else begin
      check_eq({tag, "_cnt"}, log_pc.size(), idx + 1);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // cyc at a negedge is the index of the upcoming active edge
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory: request accepted at edge k answers at edge k+lat; reset clears it
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      if (mq_due.size() > 0 && mq_due[0] == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = exp_instr(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (!reset) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (imem_req) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + lat);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset && id_valid && id_ready) begin
      log_pc.push_back(id_pc);
      log_ins.push_back(id_instr);
    end
  end

  task automatic do_reset();
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 9'd0;
    halt        = 1'b0;
    id_ready    = 1'b0;
    next();
    mid();
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_valid", id_valid, 1'b0);
    check_eq("rst_pc", id_pc, 9'd0);
    check_eq("rst_instr", id_instr, 32'd0);
    check_eq("rst_occ", occupancy, 3'd0);
    next();
    log_pc.delete();
    log_ins.delete();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 9'd0;
    halt        = 1'b0;
    id_ready    = 1'b0;

    // 1: streaming at latency 1
    lat = 1;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mid();
      check_eq("t1_req", imem_req, 1'b1);
      check_eq("t1_addr", imem_addr, 64'(i * 4));
      check_eq("t1_occ", occupancy, (i == 0) ? 64'd0 : ((i == 1) ? 64'd1 : 64'd2));
      next();
    end
    check_log("t1_log0", 0, 9'h000);
    check_log("t1_log1", 1, 9'h004);
    check_log("t1_log2", 2, 9'h008);

    // 2: fill to DEPTH with decode stalled, then drain
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mid();
      check_eq("t2_req", imem_req, 1'b1);
      check_eq("t2_addr", imem_addr, 64'(i * 4));
      next();
    end
    for (int i = 0; i < 2; i++) begin
      mid();
      check_eq("t2_full_req", imem_req, 1'b0);
      check_eq("t2_full_occ", occupancy, 3'd4);
      check_eq("t2_full_valid", id_valid, 1'b1);
      check_eq("t2_full_pc", id_pc, 9'h000);
      next();
    end
    id_ready = 1'b1;
    mid();
    check_eq("t2_pop_req", imem_req, 1'b0);
    check_eq("t2_pop_pc", id_pc, 9'h000);
    next();
    mid();
    check_eq("t2_resume_req", imem_req, 1'b1);
    check_eq("t2_resume_addr", imem_addr, 9'h010);
    check_eq("t2_resume_occ", occupancy, 3'd3);
    check_eq("t2_resume_pc", id_pc, 9'h004);
    next();
    for (int i = 0; i < 3; i++) next();
    check_log("t2_log0", 0, 9'h000);
    check_log("t2_log1", 1, 9'h004);
    check_log("t2_log2", 2, 9'h008);
    check_log("t2_log3", 3, 9'h00C);

    // 3: redirect with three requests outstanding at latency 3
    lat = 3;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("t3_addr", imem_addr, 64'(i * 4));
      next();
    end
    redirect    = 1'b1;
    redirect_pc = 9'h040;
    mid();
    check_eq("t3_redir_req", imem_req, 1'b0);
    check_eq("t3_redir_valid", id_valid, 1'b0);
    next();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("t3_req", imem_req, 1'b1);
      check_eq("t3_new_addr", imem_addr, 64'(9'h040 + 9'(i * 4)));
      check_eq("t3_wait_valid", id_valid, 1'b0);
      if (i == 0) check_eq("t3_occ0", occupancy, 3'd0);
      next();
    end
    mid();
    check_eq("t3_wait_valid", id_valid, 1'b0);
    next();
    mid();
    check_eq("t3_first_valid", id_valid, 1'b1);
    check_eq("t3_first_pc", id_pc, 9'h040);
    check_eq("t3_first_instr", id_instr, exp_instr(9'h040));
    next();
    check_log("t3_log0", 0, 9'h040);

    // 4: redirect coinciding with an rvalid and a pop
    lat = 2;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check_eq("t4_addr", imem_addr, 64'(i * 4));
      if (i == 3) check_eq("t4_head_pc", id_pc, 9'h000);
      next();
    end
    redirect    = 1'b1;
    redirect_pc = 9'h080;
    mid();
    check_eq("t4_redir_valid", id_valid, 1'b0);
    check_eq("t4_redir_req", imem_req, 1'b0);
    next();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("t4_wait_valid", id_valid, 1'b0);
      if (i == 0) begin
        check_eq("t4_occ", occupancy, 3'd0);
        check_eq("t4_new_addr", imem_addr, 9'h080);
      end
      next();
    end
    mid();
    check_eq("t4_first_valid", id_valid, 1'b1);
    check_eq("t4_first_pc", id_pc, 9'h080);
    check_eq("t4_first_instr", id_instr, exp_instr(9'h080));
    next();
    check_log("t4_log0", 0, 9'h000);
    check_log("t4_log1", 1, 9'h080);

    // 5: halt stops issue, queue drains, redirect under halt
    lat = 1;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      mid();
      check_eq("t5_addr", imem_addr, 64'(i * 4));
      next();
    end
    halt = 1'b1;
    mid();
    check_eq("t5_halt_req", imem_req, 1'b0);
    next();
    mid();
    check_eq("t5_halt_req", imem_req, 1'b0);
    check_eq("t5_occ2", occupancy, 3'd2);
    check_eq("t5_valid", id_valid, 1'b1);
    next();
    id_ready = 1'b1;
    mid();
    check_eq("t5_drain0_pc", id_pc, 9'h000);
    check_eq("t5_drain_req", imem_req, 1'b0);
    next();
    mid();
    check_eq("t5_drain1_valid", id_valid, 1'b1);
    check_eq("t5_drain1_pc", id_pc, 9'h004);
    next();
    mid();
    check_eq("t5_empty_valid", id_valid, 1'b0);
    check_eq("t5_empty_occ", occupancy, 3'd0);
    next();
    redirect    = 1'b1;
    redirect_pc = 9'h020;
    mid();
    check_eq("t5_redir_req", imem_req, 1'b0);
    next();
    redirect = 1'b0;
    mid();
    check_eq("t5_still_halted", imem_req, 1'b0);
    next();
    halt = 1'b0;
    mid();
    check_eq("t5_resume_req", imem_req, 1'b1);
    check_eq("t5_resume_addr", imem_addr, 9'h020);
    next();
    check_log("t5_log1", 1, 9'h004);

    // 6: PC wrap, then reset with requests in flight
    lat = 2;
    do_reset();
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 9'h1FC;
    mid();
    check_eq("t6_redir_req", imem_req, 1'b0);
    next();
    redirect = 1'b0;
    mid();
    check_eq("t6_addr_top", imem_addr, 9'h1FC);
    next();
    mid();
    check_eq("t6_wrap_req", imem_req, 1'b1);
    check_eq("t6_wrap_addr", imem_addr, 9'h000);
    next();
    reset = 1'b0;
    mid();
    check_eq("t6_rst_req", imem_req, 1'b0);
    next();
    reset = 1'b1;
    log_pc.delete();
    log_ins.delete();
    mid();
    check_eq("t6_post_addr", imem_addr, 9'h000);
    check_eq("t6_post_occ", occupancy, 3'd0);
    check_eq("t6_post_valid", id_valid, 1'b0);
    next();
    for (int i = 0; i < 2; i++) begin
      mid();
      check_eq("t6_wait_valid", id_valid, 1'b0);
      next();
    end
    mid();
    check_eq("t6_first_valid", id_valid, 1'b1);
    check_eq("t6_first_pc", id_pc, 9'h000);
    check_eq("t6_first_instr", id_instr, exp_instr(9'h000));
    next();
    check_log("t6_log0", 0, 9'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
